pll_reset_seq: RTL
==================

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: lock synchronizer depth, legal range 2..4.
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024: cycles lock must stay high before peripheral release, minimum 1.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16: cycles between peripheral release and CPU release, minimum 1.
REQ-004 SHALL have parameter LOST_W, default 8: width of the lock-loss counter.
REQ-005 SHALL have one clock and a synchronous, active-high reset, as listed in REQ-006 and REQ-007.
REQ-006 clk  in  1  free-running oscillator clock (27 MHz board clock), never the PLL output.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 lock  in  1  PLL lock flag, asynchronous to clk.
REQ-009 periph_rst  out  1  active-high peripheral reset, registered.
REQ-010 cpu_rst  out  1  active-high CPU reset, registered.
REQ-011 lost_pulse  out  1  one-cycle strobe on each counted lock loss, registered.
REQ-012 lost_cnt  out  LOST_W  saturating count of counted lock losses.

Function
REQ-013 SHALL pass lock through a SYNC_STAGES flip-flop chain; lock_sync is the last stage, and the FSM uses only lock_sync.
REQ-014 SHALL implement a Moore FSM with states WAIT_LOCK, STABLE, HOLD and RUN, plus one shared counter sized for max(STABLE_CYCLES, HOLD_CYCLES).
REQ-015 In WAIT_LOCK, when lock_sync=1, the FSM SHALL go to STABLE with the counter at 0; otherwise it SHALL stay.
REQ-016 In STABLE with lock_sync=1, the FSM SHALL go to HOLD with the counter at 0 when the counter equals STABLE_CYCLES-1; otherwise the counter SHALL increment.
REQ-017 In STABLE with lock_sync=0, the FSM SHALL go to WAIT_LOCK; the counter clears and the event is not counted.
REQ-018 In HOLD with lock_sync=1, the FSM SHALL go to RUN when the counter equals HOLD_CYCLES-1; otherwise the counter SHALL increment.
REQ-019 In HOLD or RUN with lock_sync=0, the FSM SHALL go to WAIT_LOCK and count one lock loss.
REQ-020 Outputs SHALL update on the same edge as the state; no combinational path from any input to any output.
- periph_rst=1 in WAIT_LOCK and STABLE.
- cpu_rst=1 in every state except RUN.
REQ-021 On each counted loss, lost_cnt SHALL increment by 1 and saturate at 2^LOST_W-1; lost_pulse SHALL be 1 for exactly that one cycle, including when lost_cnt is saturated.
REQ-022 Latency from the first clk edge that samples lock=1 (E0):
- periph_rst falls at edge E0+SYNC_STAGES+STABLE_CYCLES.
- cpu_rst falls HOLD_CYCLES edges later.
REQ-023 Latency from the first edge that samples lock=0 in HOLD or RUN (F0): both resets and lost_pulse are 1 from edge F0+SYNC_STAGES.
REQ-024 A lock glitch shorter than one clk period SHALL be either ignored or fully handled per REQ-017/REQ-019; no partial or intermediate output state is allowed.

Reset
REQ-025 With rst=1 at an edge, the block SHALL set state=WAIT_LOCK, counter=0, all synchronizer stages=0, periph_rst=1, cpu_rst=1, lost_pulse=0 and lost_cnt=0.
REQ-026 rst SHALL take priority over every FSM transition, including in RUN.
REQ-027 If lock is still high when rst is released, the sequence SHALL restart per REQ-022, counting from the first edge with rst=0.

Verification (SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, LOST_W=2)
REQ-028 Power-up: lock rises, first sampled at E0 -> periph_rst 1->0 at E10, cpu_rst 1->0 at E14, lost_cnt=0.
REQ-029 Loss in RUN: lock falls, sampled at F0 -> at F2 periph_rst=1, cpu_rst=1, lost_pulse=1 for one cycle, lost_cnt=1.
REQ-030 Drop in STABLE: lock low for 3 cycles starting 4 cycles after STABLE entry -> return to WAIT_LOCK, lost_cnt unchanged. On relock, the full 8-cycle STABLE window restarts.
REQ-031 Saturation: 5 lock losses from RUN -> lost_cnt reads 1, 2, 3, 3, 3, and lost_pulse fires all 5 times.
REQ-032 Reset mid-RUN with lock held high, rst=1 for 1 cycle at edge R -> at R: both resets=1, lost_cnt=0; then cpu_rst=0 at edge R+15 (R+1 plus 14).
REQ-033 Loss in HOLD: lock drops 2 cycles after HOLD entry -> cpu_rst never deasserts, periph_rst reasserts per REQ-023, lost_cnt increments.

Source files
------------

// File: rtl/pll_reset_seq.sv
// ============================================================================
// Module  : pll_reset_seq
// Brief   : Sequences peripheral/CPU reset release from a synchronised PLL
//           lock flag and counts lock losses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pll_reset_seq #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int LOST_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lock,
    output logic              periph_rst,
    output logic              cpu_rst,
    output logic              lost_pulse,
    output logic [LOST_W-1:0] lost_cnt
);

    localparam int c_CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST   = c_CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                   r_state;
    logic [c_CNT_W-1:0]       r_cnt;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_periph_rst;
    logic                     r_cpu_rst;
    logic                     r_lost_pulse;
    logic [LOST_W-1:0]        r_lost_cnt;
    logic                     w_lock_sync;

    // Lock is asynchronous to clk; only the last stage is ever looked at.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], lock};
        end
    end

    assign w_lock_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= WAIT_LOCK;
            r_cnt        <= '0;
            r_periph_rst <= 1'b1;
            r_cpu_rst    <= 1'b1;
            r_lost_pulse <= 1'b0;
            r_lost_cnt   <= '0;
        end else begin
            r_lost_pulse <= 1'b0;
            case (r_state)
                WAIT_LOCK: begin
                    if (w_lock_sync) begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end
                end
                STABLE: begin
                    // A drop before release is not a loss: nothing was running yet.
                    if (!w_lock_sync) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_STABLE_LAST) begin
                        r_state      <= HOLD;
                        r_cnt        <= '0;
                        r_periph_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HOLD, RUN: begin
                    if (!w_lock_sync) begin
                        r_state      <= WAIT_LOCK;
                        r_cnt        <= '0;
                        r_periph_rst <= 1'b1;
                        r_cpu_rst    <= 1'b1;
                        r_lost_pulse <= 1'b1;
                        if (r_lost_cnt != {LOST_W{1'b1}}) begin
                            r_lost_cnt <= r_lost_cnt + 1'b1;
                        end
                    end else if (r_state == HOLD) begin
                        if (r_cnt == c_HOLD_LAST) begin
                            r_state   <= RUN;
                            r_cnt     <= '0;
                            r_cpu_rst <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state      <= WAIT_LOCK;
                    r_cnt        <= '0;
                    r_periph_rst <= 1'b1;
                    r_cpu_rst    <= 1'b1;
                end
            endcase
        end
    end

    assign periph_rst = r_periph_rst;
    assign cpu_rst    = r_cpu_rst;
    assign lost_pulse = r_lost_pulse;
    assign lost_cnt   = r_lost_cnt;

endmodule

`default_nettype wire
